// File: rtl/out_tile_writer_pkg.sv
// out_tile_writer_pkg
//   Shared definitions for the matrix-multiply output path: writer state
//   encoding, tile-count derivation and the BRAM byte write-enable constants.
package out_tile_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } wr_state_e;

  localparam logic [7:0] WEA_ALL  = 8'hFF;
  localparam logic [7:0] WEA_NONE = 8'h00;

  // Number of tiles in result matrix C (tile rows x tile columns).
  function automatic int calc_max_flag(input int rows, input int cols);
    return rows * cols;
  endfunction

endpackage

// File: rtl/out_tile_writer_fifo.sv
// sync_fifo
//   Single-clock tile buffer with a fall-through head (dout always shows the
//   oldest entry while not empty). A push into a full FIFO is taken only when
//   a pop happens in the same cycle, so occupancy stays unchanged.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear         synchronous flush (empties the buffer)
//   push / din    write request and data
//   pop           remove head (ignored while empty)
//   dout          head entry
//   full, empty   occupancy flags
module sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/out_tile_writer.sv
// out_tile_writer
//   Collects finished accumulator tiles, buffers them and writes each one to
//   the output BRAM at address row*COL_SIZE_MAT_C+col, in arrival order.
// Handshake: acc_valid is a one-cycle push with no back-pressure (a tile that
//   finds the buffer full and not draining is dropped and flagged). ob_grant
//   acts as the ready of the BRAM side: a write is issued only in a cycle
//   where the buffer has data and ob_grant=1; the write appears registered on
//   ob_ena/ob_wea/ob_addra/ob_dina one edge later.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                one-cycle job start (only honoured in IDLE)
//   acc_valid, acc_data  finished tile from the accumulator
//   ob_grant             BRAM port A available this cycle
//   ob_ena, ob_wea, ob_addra, ob_dina   BRAM port A write
//   busy, done           job in progress / one-cycle completion pulse
//   overflow             sticky: a tile was dropped or was surplus
//   tiles_written        tiles committed this job
//   state_dbg            current FSM state (wr_state_e encoding)
module out_tile_writer
  import out_tile_writer_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int CHUNK_SIZE     = 4,
  parameter int ROW_SIZE_MAT_C = 3,
  parameter int COL_SIZE_MAT_C = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_WIDTH     = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          acc_valid,
  input  logic [WIDTH*CHUNK_SIZE-1:0]   acc_data,
  input  logic                          ob_grant,
  output logic                          ob_ena,
  output logic [7:0]                    ob_wea,
  output logic [ADDR_WIDTH-1:0]         ob_addra,
  output logic [WIDTH*CHUNK_SIZE-1:0]   ob_dina,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [ADDR_WIDTH-1:0]         tiles_written,
  output logic [1:0]                    state_dbg
);

  localparam int DW       = WIDTH * CHUNK_SIZE;
  localparam int MAX_FLAG = calc_max_flag(ROW_SIZE_MAT_C, COL_SIZE_MAT_C);

  wr_state_e             state, state_nx;
  logic                  start_job;
  logic                  take_tile;
  logic                  drop_tile;
  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DW-1:0]         fifo_head;
  logic [ADDR_WIDTH-1:0] tile_cnt;
  logic [ADDR_WIDTH-1:0] row;
  logic [ADDR_WIDTH-1:0] col;
  logic                  last_tile;

  // tile_cnt counts every tile offered in RUN, dropped ones included, so the
  // job still leaves RUN after the MAX_FLAG-th valid even when some were lost.
  assign last_tile = (tile_cnt == ADDR_WIDTH'(MAX_FLAG - 1));
  assign state_dbg = state;

  sync_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (start_job),
    .push  (push),
    .pop   (pop),
    .din   (acc_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    start_job = 1'b0;
    take_tile = 1'b0;
    drop_tile = 1'b0;
    pop       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          start_job = 1'b1;
          state_nx  = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        pop  = ~fifo_empty & ob_grant;
        if (acc_valid) begin
          take_tile = 1'b1;
          drop_tile = fifo_full & ~pop;
          if (last_tile) state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy      = 1'b1;
        pop       = ~fifo_empty & ob_grant;
        drop_tile = acc_valid;
        // No pushes happen in DRAIN, so an empty buffer means every
        // accepted tile has been committed.
        if (fifo_empty) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign push = take_tile & ~drop_tile;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ob_ena        <= 1'b0;
      ob_wea        <= WEA_NONE;
      ob_addra      <= '0;
      ob_dina       <= '0;
      overflow      <= 1'b0;
      tiles_written <= '0;
      tile_cnt      <= '0;
      row           <= '0;
      col           <= '0;
    end else begin
      ob_ena <= 1'b0;
      ob_wea <= WEA_NONE;
      if (start_job) begin
        overflow      <= 1'b0;
        tiles_written <= '0;
        tile_cnt      <= '0;
        row           <= '0;
        col           <= '0;
      end else begin
        if (take_tile) tile_cnt <= tile_cnt + 1'b1;
        if (drop_tile) overflow <= 1'b1;
        if (pop) begin
          ob_ena        <= 1'b1;
          ob_wea        <= WEA_ALL;
          ob_addra      <= row * ADDR_WIDTH'(COL_SIZE_MAT_C) + col;
          ob_dina       <= fifo_head;
          tiles_written <= tiles_written + 1'b1;
          if (col == ADDR_WIDTH'(COL_SIZE_MAT_C - 1)) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_out_tile_writer.sv
`timescale 1ns/1ps
module tb_out_tile_writer;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int ROWS  = 3;
  localparam int COLS  = 3;
  localparam int DEPTH = 4;
  localparam int AW    = 12;
  localparam int DW    = WIDTH * CHUNK;
  localparam int MAXF  = ROWS * COLS;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          acc_valid = 1'b0;
  logic [DW-1:0] acc_data = '0;
  logic          ob_grant = 1'b0;
  logic          ob_ena;
  logic [7:0]    ob_wea;
  logic [AW-1:0] ob_addra;
  logic [DW-1:0] ob_dina;
  logic          busy;
  logic          done;
  logic          overflow;
  logic [AW-1:0] tiles_written;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  out_tile_writer #(
    .WIDTH          (WIDTH),
    .CHUNK_SIZE     (CHUNK),
    .ROW_SIZE_MAT_C (ROWS),
    .COL_SIZE_MAT_C (COLS),
    .FIFO_DEPTH     (DEPTH),
    .ADDR_WIDTH     (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .acc_valid     (acc_valid),
    .acc_data      (acc_data),
    .ob_grant      (ob_grant),
    .ob_ena        (ob_ena),
    .ob_wea        (ob_wea),
    .ob_addra      (ob_addra),
    .ob_dina       (ob_dina),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .tiles_written (tiles_written),
    .state_dbg     (state_dbg)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Job phases: 0 idle, 1 collecting tiles, 2 draining, 3 done pulse.
  // The buffer is a queue; a tile fits if there is room after this cycle's
  // write has left it. Addresses are simply the running write index.
  int            m_phase = 0;
  logic [DW-1:0] m_q[$];
  int            m_seen = 0;
  int            m_written = 0;
  logic          m_ovf = 1'b0;
  logic          m_ena = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk) begin
    bit            popping;
    bit            was_empty;
    logic [DW-1:0] head;
    if (rst) begin
      m_phase = 0; m_q.delete(); m_seen = 0; m_written = 0;
      m_ovf = 1'b0; m_ena = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      m_ena     = 1'b0;
      was_empty = (m_q.size() == 0);
      popping   = (m_phase == 1 || m_phase == 2) && !was_empty && ob_grant;
      head      = was_empty ? '0 : m_q[0];
      if (popping) begin
        void'(m_q.pop_front());
        m_ena  = 1'b1;
        m_addr = AW'(m_written);
        m_data = head;
        m_written++;
      end
      case (m_phase)
        0: if (start) begin
             m_phase = 1; m_q.delete(); m_seen = 0; m_written = 0; m_ovf = 1'b0;
           end
        1: if (acc_valid) begin
             m_seen++;
             if (m_q.size() < DEPTH) m_q.push_back(acc_data);
             else                    m_ovf = 1'b1;
             if (m_seen == MAXF) m_phase = 2;
           end
        2: begin
             if (acc_valid) m_ovf = 1'b1;
             if (was_empty) m_phase = 3;
           end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];
  int            done_cnt = 0;

  always @(posedge clk) begin
    #1;
    check("ob_ena",        ob_ena,        m_ena);
    check("ob_wea",        ob_wea,        m_ena ? 8'hFF : 8'h00);
    check("ob_addra",      ob_addra,      m_addr);
    check("ob_dina",       ob_dina,       m_data);
    check("busy",          busy,          (m_phase == 1 || m_phase == 2));
    check("done",          done,          (m_phase == 3));
    check("overflow",      overflow,      m_ovf);
    check("tiles_written", tiles_written, AW'(m_written));
    if (ob_ena) begin
      got_addr.push_back(ob_addra);
      got_data.push_back(ob_dina);
    end
    if (done) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_tile();
    return {$urandom, $urandom};
  endfunction

  task automatic send_tile(input logic [DW-1:0] d);
    acc_valid = 1'b1;
    acc_data  = d;
    exp_q.push_back(d);
    @(negedge clk);
    acc_valid = 1'b0;
  endtask

  task automatic clear_logs();
    exp_q.delete();
    got_addr.delete();
    got_data.delete();
    done_cnt = 0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished"}, busy, 1'b0);
    cyc_n(2);
  endtask

  task automatic check_writes(input string tag, input int n_exp);
    check({tag, "_nwrites"}, 64'(got_addr.size()), 64'(n_exp));
    for (int i = 0; i < n_exp && i < got_addr.size() && i < exp_q.size(); i++) begin
      check({tag, "_addr"}, 64'(got_addr[i]), 64'(i));
      check({tag, "_data"}, got_data[i], exp_q[i]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ena"},   ob_ena,        1'b0);
    check({tag, "_wea"},   ob_wea,        8'h00);
    check({tag, "_addra"}, ob_addra,      '0);
    check({tag, "_dina"},  ob_dina,       '0);
    check({tag, "_busy"},  busy,          1'b0);
    check({tag, "_done"},  done,          1'b0);
    check({tag, "_ovf"},   overflow,      1'b0);
    check({tag, "_tw"},    tiles_written, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    cyc_n(3);
    check_all_zero("reset");
    rst = 1'b0;
    cyc_n(2);

    // nominal: 9 tiles every 35 cycles, grant always high, with latency probe
    clear_logs();
    ob_grant = 1'b1;
    pulse_start();
    acc_valid = 1'b1;
    acc_data  = rnd_tile();
    exp_q.push_back(acc_data);
    @(posedge clk); #1;
    check("lat_edge1_ena", ob_ena, 1'b0);
    @(negedge clk);
    acc_valid = 1'b0;
    @(posedge clk); #1;
    check("lat_edge2_ena", ob_ena, 1'b1);
    @(negedge clk);
    cyc_n(33);
    for (int i = 1; i < MAXF; i++) begin
      send_tile(rnd_tile());
      if (i < MAXF - 1) cyc_n(34);
    end
    wait_idle(200, "nom");
    check_writes("nom", MAXF);
    check("nom_done_cnt", 64'(done_cnt), 64'd1);
    check("nom_tw", tiles_written, AW'(MAXF));
    check("nom_ovf", overflow, 1'b0);
    cyc_n(5);
    check("nom_tw_hold", tiles_written, AW'(MAXF));

    // backpressure: 4 tiles over 20 cycles of no grant, then release
    clear_logs();
    ob_grant = 1'b0;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      send_tile(rnd_tile());
      cyc_n(4);
    end
    check("bp_held_writes", 64'(got_addr.size()), 64'd0);
    ob_grant = 1'b1;
    cyc_n(10);
    check_writes("bp", 4);
    check("bp_ovf", overflow, 1'b0);
    for (int i = 0; i < MAXF - 4; i++) begin
      send_tile(rnd_tile());
      cyc_n(2);
    end
    wait_idle(200, "bp");
    check_writes("bp_all", MAXF);

    // overflow: 5 back-to-back tiles with no grant, 5th dropped
    clear_logs();
    ob_grant = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) send_tile(rnd_tile());
    void'(exp_q.pop_back());
    check("ovf_flag", overflow, 1'b1);
    cyc_n(5);
    check("ovf_held_writes", 64'(got_addr.size()), 64'd0);
    ob_grant = 1'b1;
    cyc_n(10);
    check_writes("ovf", 4);
    for (int i = 0; i < MAXF - 5; i++) send_tile(rnd_tile());
    wait_idle(200, "ovf");
    check_writes("ovf_all", MAXF - 1);
    check("ovf_tw", tiles_written, AW'(MAXF - 1));
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_done_cnt", 64'(done_cnt), 64'd1);

    // full buffer with simultaneous push and pop
    clear_logs();
    ob_grant = 1'b0;
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send_tile(rnd_tile());
    ob_grant = 1'b1;
    send_tile(rnd_tile());
    ob_grant = 1'b0;
    check("sim_no_drop", overflow, 1'b0);
    check("sim_one_write", 64'(got_addr.size()), 64'd1);
    send_tile(rnd_tile());             // buffer is full again: this one is lost
    void'(exp_q.pop_back());
    check("sim_full_again", overflow, 1'b1);
    ob_grant = 1'b1;
    for (int i = 0; i < MAXF - DEPTH - 2; i++) begin
      send_tile(rnd_tile());
      cyc_n(3);
    end
    wait_idle(200, "sim");
    check_writes("sim", MAXF - 1);

    // surplus: 10 back-to-back tiles, the 10th arrives while draining
    clear_logs();
    ob_grant = 1'b1;
    pulse_start();
    for (int i = 0; i < MAXF + 1; i++) send_tile(rnd_tile());
    void'(exp_q.pop_back());
    wait_idle(200, "sur");
    check_writes("sur", MAXF);
    check("sur_ovf", overflow, 1'b1);
    check("sur_tw", tiles_written, AW'(MAXF));
    check("sur_done_cnt", 64'(done_cnt), 64'd1);

    // reset mid-job after 5 writes, then a clean restart
    clear_logs();
    ob_grant = 1'b1;
    pulse_start();
    for (int i = 0; i < MAXF - 1 && got_addr.size() < 5; i++) begin
      send_tile(rnd_tile());
      cyc_n(2);
    end
    check("rstmid_writes", 64'(got_addr.size()), 64'd5);
    rst = 1'b1;
    #1;
    check_all_zero("rstmid");
    cyc_n(2);
    rst = 1'b0;
    cyc_n(1);
    clear_logs();
    pulse_start();
    for (int i = 0; i < MAXF; i++) send_tile(rnd_tile());
    wait_idle(200, "restart");
    check_writes("restart", MAXF);
    check("restart_ovf", overflow, 1'b0);

    // randomized jobs, checked cycle by cycle against the model
    for (int j = 0; j < 6; j++) begin
      int n;
      clear_logs();
      repeat ($urandom_range(0, 2)) begin
        acc_valid = 1'b1;
        acc_data  = rnd_tile();
        @(negedge clk);
        acc_valid = 1'b0;
      end
      pulse_start();
      n = 0;
      while (busy && n < 800) begin
        ob_grant  = ($urandom_range(0, 9) < 7);
        acc_valid = ($urandom_range(0, 2) == 0);
        acc_data  = rnd_tile();
        start     = ($urandom_range(0, 15) == 0);
        @(negedge clk);
        n++;
      end
      acc_valid = 1'b0;
      start     = 1'b0;
      ob_grant  = 1'b1;
      check("rnd_finished", busy, 1'b0);
      cyc_n(2);
      check("rnd_done_cnt", 64'(done_cnt), 64'd1);
    end

    cyc_n(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
